// File: rtl/lcd_pkg.sv
// Shared types and default timing for the HD44780 4-bit read path.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    E1_HI,
    E1_LO,
    E2_HI,
    E2_LO,
    DONE
  } lcd_state_t;

  localparam int DEF_SETUP_CYC  = 2;
  localparam int DEF_E_HIGH_CYC = 12;
  localparam int DEF_SAMPLE_CYC = 8;
  localparam int DEF_E_LOW_CYC  = 10;

  localparam int LCD_BF_BIT = 7;

  localparam logic RS_STATUS = 1'b0;
  localparam logic RS_DATA   = 1'b1;

  function automatic logic is_e_high(lcd_state_t s);
    return (s == E1_HI) || (s == E2_HI);
  endfunction

endpackage

// File: rtl/lcd_e_pulse_gen.sv
// Phase timer for the read FSM: counts clocks in each timed state and flags
// the end of the phase plus the d_in sample point inside an E-high window.
module lcd_e_pulse_gen
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int E_HIGH_CYC = DEF_E_HIGH_CYC,
  parameter int SAMPLE_CYC = DEF_SAMPLE_CYC,
  parameter int E_LOW_CYC  = DEF_E_LOW_CYC
) (
  input  logic       clock,
  input  logic       reset,
  input  lcd_state_t state,
  output logic       phase_done,
  output logic       sample
);

  logic [15:0] cnt;
  logic [15:0] limit;
  logic        timed;

  // SETUP ends at cnt==SETUP_CYC so the accept cycle plus SETUP_CYC clocks precede E.
  always_comb begin
    limit = '0;
    timed = 1'b1;
    case (state)
      SETUP:        limit = 16'(SETUP_CYC);
      E1_HI, E2_HI: limit = 16'(E_HIGH_CYC - 1);
      E1_LO, E2_LO: limit = 16'(E_LOW_CYC - 1);
      default:      timed = 1'b0;
    endcase
  end

  assign phase_done = timed && (cnt == limit);
  assign sample     = is_e_high(state) && (cnt == 16'(SAMPLE_CYC));

  always_ff @(posedge clock) begin
    if (reset || !timed || phase_done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/lcd_nibble_reader.sv
// HD44780 4-bit read cycle: two E pulses, high then low nibble, returned as one byte.
// Define LCD_BUSY_POLL_EN to re-read status automatically while the busy flag is set.
module lcd_nibble_reader
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int E_HIGH_CYC = DEF_E_HIGH_CYC,
  parameter int SAMPLE_CYC = DEF_SAMPLE_CYC,
  parameter int E_LOW_CYC  = DEF_E_LOW_CYC
`ifdef LCD_BUSY_POLL_EN
  , parameter int MAX_POLLS = 255
`endif
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       rs_sel,
  output logic       ready,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       timeout,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  input  logic [3:0] lcd_d_in,
  output logic       lcd_d_oe
);

  lcd_state_t state;
  logic [3:0] hi;
  logic [3:0] lo;
  logic       phase_done;
  logic       sample;
  logic       retry;

  lcd_e_pulse_gen #(
    .SETUP_CYC (SETUP_CYC),
    .E_HIGH_CYC(E_HIGH_CYC),
    .SAMPLE_CYC(SAMPLE_CYC),
    .E_LOW_CYC (E_LOW_CYC)
  ) u_pulse (
    .clock     (clock),
    .reset     (reset),
    .state     (state),
    .phase_done(phase_done),
    .sample    (sample)
  );

`ifdef LCD_BUSY_POLL_EN
  logic [15:0] poll_cnt;
  logic        busy;

  assign busy  = (lcd_rs == RS_STATUS) && hi[LCD_BF_BIT - 4];
  assign retry = busy && (poll_cnt != 16'(MAX_POLLS));

  always_ff @(posedge clock) begin
    if (reset) begin
      poll_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (state == IDLE && start) begin
        poll_cnt <= '0;
      end else if (state == E2_LO && phase_done) begin
        if (retry) begin
          poll_cnt <= poll_cnt + 16'd1;
        end else begin
          timeout <= busy;
        end
      end
    end
  end
`else
  assign retry   = 1'b0;
  assign timeout = 1'b0;
`endif

  // A retried poll keeps lcd_rw high into DONE, which is how DONE knows to loop back.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      ready    <= 1'b1;
      valid    <= 1'b0;
      data_out <= 8'h00;
      lcd_e    <= 1'b0;
      lcd_rw   <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_d_oe <= 1'b1;
      hi       <= '0;
      lo       <= '0;
    end else begin
      valid <= 1'b0;
      if (sample) begin
        if (state == E1_HI) hi <= lcd_d_in;
        else                lo <= lcd_d_in;
      end
      case (state)
        IDLE: if (start) begin
          lcd_rs   <= rs_sel;
          lcd_rw   <= 1'b1;
          lcd_d_oe <= 1'b0;
          ready    <= 1'b0;
          state    <= SETUP;
        end
        SETUP: if (phase_done) begin
          lcd_e <= 1'b1;
          state <= E1_HI;
        end
        E1_HI: if (phase_done) begin
          lcd_e <= 1'b0;
          state <= E1_LO;
        end
        E1_LO: if (phase_done) begin
          lcd_e <= 1'b1;
          state <= E2_HI;
        end
        E2_HI: if (phase_done) begin
          lcd_e <= 1'b0;
          state <= E2_LO;
        end
        E2_LO: if (phase_done) begin
          state <= DONE;
          if (!retry) begin
            data_out <= {hi, lo};
            valid    <= 1'b1;
            lcd_rw   <= 1'b0;
          end
        end
        DONE: begin
          if (lcd_rw) begin
            state <= SETUP;
          end else begin
            state    <= IDLE;
            ready    <= 1'b1;
            lcd_d_oe <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_nibble_reader.sv
// Scoreboard bench for lcd_nibble_reader; the poll cases build only with LCD_BUSY_POLL_EN.
module tb_lcd_nibble_reader;
  import lcd_pkg::*;

  typedef struct packed {
    logic [7:0] data;
    logic       to;
  } exp_t;

  localparam logic [3:0] BUSY_NIB = 4'(1 << (LCD_BF_BIT - 4));

  logic       clock;
  logic       reset;
  logic       start;
  logic       rs_sel;
  logic       ready;
  logic [7:0] data_out;
  logic       valid;
  logic       timeout;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [3:0] lcd_d_in;
  logic       lcd_d_oe;

  int n_compared;
  int n_mismatched;
  int valid_seen;

  exp_t       sb_q[$];
  logic [3:0] nib_q[$];

  lcd_nibble_reader #(
    .SETUP_CYC (2),
    .E_HIGH_CYC(12),
    .SAMPLE_CYC(8),
    .E_LOW_CYC (10)
`ifdef LCD_BUSY_POLL_EN
    , .MAX_POLLS(4)
`endif
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .rs_sel  (rs_sel),
    .ready   (ready),
    .data_out(data_out),
    .valid   (valid),
    .timeout (timeout),
    .lcd_rs  (lcd_rs),
    .lcd_rw  (lcd_rw),
    .lcd_e   (lcd_e),
    .lcd_d_in(lcd_d_in),
    .lcd_d_oe(lcd_d_oe)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // LCD side: present the next queued nibble each time E rises.
  always @(posedge lcd_e) begin
    if (nib_q.size() > 0) lcd_d_in = nib_q.pop_front();
  end

  // Monitor pops one expectation per valid pulse.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && valid) begin
      valid_seen++;
      if (sb_q.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL unexpected_valid: got data_out=%0h, expected no valid", data_out);
      end else begin
        e = sb_q.pop_front();
        check_output("data_out", 32'(data_out), 32'(e.data));
        check_output("timeout", 32'(timeout), 32'(e.to));
      end
    end
  end

  task automatic expect_read(input logic [3:0] h, input logic [3:0] l,
                             input logic [7:0] data, input logic to);
    exp_t e;
    nib_q.push_back(h);
    nib_q.push_back(l);
    e.data = data;
    e.to   = to;
    sb_q.push_back(e);
  endtask

  // Issue one read from a negedge and follow it until valid; exp_lat counts edges from accept.
  task automatic apply_stimulus(input logic rs, input int exp_lat, input bit extra_starts, input string tag);
    int lat;
    bit rs_ok;
    lat   = -1;
    rs_ok = 1'b1;
    rs_sel = rs;
    start  = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 1; i <= 2000 && lat < 0; i++) begin
      if (extra_starts && (i == 10 || i == 30)) start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      if (lcd_rs !== rs) rs_ok = 1'b0;
      if (valid === 1'b1) lat = i;
    end
    if (lat < 0) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL %s_no_valid: got no valid within 2000 cycles, expected valid", tag);
    end else begin
      check_output({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check_output({tag, "_rs_held"}, 32'(rs_ok), 32'd1);
      check_output({tag, "_ready_at_valid"}, 32'(ready), 32'd0);
      check_output({tag, "_rw_at_valid"}, 32'(lcd_rw), 32'd0);
      check_output({tag, "_oe_at_valid"}, 32'(lcd_d_oe), 32'd0);
      @(negedge clock);
      check_output({tag, "_ready_after"}, 32'(ready), 32'd1);
      check_output({tag, "_oe_after"}, 32'(lcd_d_oe), 32'd1);
    end
  endtask

  initial begin
    int seen_before;
    n_compared   = 0;
    n_mismatched = 0;
    valid_seen   = 0;
    reset    = 1'b1;
    start    = 1'b0;
    rs_sel   = 1'b0;
    lcd_d_in = 4'h0;
    repeat (3) @(negedge clock);
    check_output("rst_ready", 32'(ready), 32'd1);
    check_output("rst_valid", 32'(valid), 32'd0);
    check_output("rst_timeout", 32'(timeout), 32'd0);
    check_output("rst_data", 32'(data_out), 32'h00);
    check_output("rst_e", 32'(lcd_e), 32'd0);
    check_output("rst_rw", 32'(lcd_rw), 32'd0);
    check_output("rst_rs", 32'(lcd_rs), 32'd0);
    check_output("rst_oe", 32'(lcd_d_oe), 32'd1);
    reset = 1'b0;
    @(negedge clock);

    $display("[TB] data read A/5");
    expect_read(4'hA, 4'h5, 8'hA5, 1'b0);
    apply_stimulus(RS_DATA, 47, 1'b0, "t1");
    repeat (3) @(negedge clock);

    $display("[TB] status read 3/C");
    expect_read(4'h3, 4'hC, 8'h3C, 1'b0);
    apply_stimulus(RS_STATUS, 47, 1'b0, "t2");
    repeat (3) @(negedge clock);

    $display("[TB] extra starts ignored");
    seen_before = valid_seen;
    expect_read(4'h6, 4'h9, 8'h69, 1'b0);
    apply_stimulus(RS_DATA, 47, 1'b1, "t3");
    repeat (60) @(negedge clock);
    check_output("t3_one_valid", 32'(valid_seen - seen_before), 32'd1);

    $display("[TB] reset mid-read");
    seen_before = valid_seen;
    nib_q.push_back(4'hE);
    rs_sel = RS_DATA;
    start  = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (19) @(negedge clock);
    check_output("t4_rw_before", 32'(lcd_rw), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_output("t4_e", 32'(lcd_e), 32'd0);
    check_output("t4_rw", 32'(lcd_rw), 32'd0);
    check_output("t4_oe", 32'(lcd_d_oe), 32'd1);
    check_output("t4_ready", 32'(ready), 32'd1);
    repeat (60) @(negedge clock);
    check_output("t4_no_valid", 32'(valid_seen - seen_before), 32'd0);
    nib_q.delete();

`ifdef LCD_BUSY_POLL_EN
    $display("[TB] busy poll clears after 3 reads");
    nib_q.push_back(BUSY_NIB); nib_q.push_back(4'h0);
    nib_q.push_back(BUSY_NIB); nib_q.push_back(4'h0);
    nib_q.push_back(BUSY_NIB); nib_q.push_back(4'h0);
    expect_read(4'h0, 4'h7, 8'h07, 1'b0);
    apply_stimulus(RS_STATUS, 191, 1'b0, "t5");
    repeat (3) @(negedge clock);

    $display("[TB] busy stuck hits poll limit");
    for (int k = 0; k < 4; k++) begin
      nib_q.push_back(BUSY_NIB);
      nib_q.push_back(4'hF);
    end
    expect_read(BUSY_NIB, 4'hF, 8'h8F, 1'b1);
    apply_stimulus(RS_STATUS, 239, 1'b0, "t6");
    repeat (3) @(negedge clock);
`else
    $display("[TB] busy flag returned without polling");
    expect_read(BUSY_NIB, 4'h0, 8'h80, 1'b0);
    apply_stimulus(RS_STATUS, 47, 1'b0, "t5");
    repeat (3) @(negedge clock);
`endif

    $display("[TB] recovery read 3/F");
    expect_read(4'h3, 4'hF, 8'h3F, 1'b0);
    apply_stimulus(RS_DATA, 47, 1'b0, "t7");
    repeat (20) @(negedge clock);
    check_output("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
